// File: rtl/jacaranda_wb_pkg.sv
// Shared definitions for the jacaranda Wishbone memory loaders.
// Contents: register offsets, the loader state encoding and a byte-lane helper.
package jacaranda_wb_pkg;

    localparam logic [15:0] CTRL_OFF      = 16'h0000;
    localparam logic [15:0] WCNT_OFF      = 16'h0004;
    localparam logic [15:0] IMEM_BASE_OFF = 16'h1000;
    localparam int          IMEM_SIZE     = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_CAPT = 2'd2,
        ST_ACK  = 2'd3
    } loader_state_t;

    function automatic logic in_mem_window(input logic [15:0] off,
                                           input logic [15:0] base_off);
        return off[15:8] == base_off[15:8];
    endfunction

    // Little-endian lane select: lane i is bits 8i+7:8i.
    function automatic logic [7:0] get_lane(input logic [31:0] word,
                                            input logic [1:0]  lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/wb_imem_loader_if.sv
// Wishbone classic slave-side bundle between the user-area port and the loader.
interface wb_imem_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_imem_loader.sv
// Wishbone loader for the jacaranda-8 instruction memory: holds the core in reset,
// serialises 32-bit bus words into four byte accesses and reports a write count.
import jacaranda_wb_pkg::*;

module wb_imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_imem_loader_if.slave  wbs,
    output logic             cpu_rst_o,
    output logic [7:0]       imem_addr_o,
    output logic             imem_we_o,
    output logic [7:0]       imem_wdata_o,
    input  logic [7:0]       imem_rdata_i,
    output logic             imem_own_o
);

    loader_state_t r_state;
    logic [1:0]    r_lane;
    logic [5:0]    r_word;
    logic [31:0]   r_dat;
    logic [3:0]    r_sel;
    logic          r_we;
    logic [31:0]   r_rbuf;
    logic          r_cpu_rst;
    logic          r_err;
    logic [15:0]   r_wcnt;
    logic          r_ack;
    logic [31:0]   r_dat_o;
    logic [7:0]    r_imem_addr;
    logic          r_imem_we;
    logic [7:0]    r_imem_wdata;

    logic [15:0]   w_off;
    logic          w_req;
    logic          w_is_imem;
    logic          w_is_ctrl;
    logic          w_is_wcnt;
    logic [1:0]    w_next_lane;
    logic [31:0]   w_rd_val;

    assign w_off       = wbs.wbs_adr_i[15:0];
    assign w_req       = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                         (wbs.wbs_adr_i[31:16] == BASE_ADDR[31:16]);
    assign w_is_imem   = in_mem_window(w_off, IMEM_BASE_OFF);
    assign w_is_ctrl   = (w_off == CTRL_OFF);
    assign w_is_wcnt   = (w_off == WCNT_OFF);
    assign w_next_lane = r_lane + 2'd1;

    // Register-read mux for single-cycle accesses (IMEM window is never served here).
    always_comb begin
        w_rd_val = 32'd0;
        if (w_is_imem) begin
            w_rd_val = 32'd0;
        end else if (w_is_ctrl) begin
            w_rd_val = {30'd0, r_err, r_cpu_rst};
        end else if (w_is_wcnt) begin
            w_rd_val = {16'd0, r_wcnt};
        end else begin
            w_rd_val = 32'd0;
        end
    end

    // Transaction FSM with all bus and memory-port outputs registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_lane       <= 2'd0;
            r_word       <= 6'd0;
            r_dat        <= 32'd0;
            r_sel        <= 4'd0;
            r_we         <= 1'b0;
            r_rbuf       <= 32'd0;
            r_cpu_rst    <= 1'b1;
            r_err        <= 1'b0;
            r_wcnt       <= 16'd0;
            r_ack        <= 1'b0;
            r_dat_o      <= 32'd0;
            r_imem_addr  <= 8'd0;
            r_imem_we    <= 1'b0;
            r_imem_wdata <= 8'd0;
        end else begin
            if (r_imem_we) begin
                r_wcnt <= r_wcnt + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_word <= w_off[7:2];
                        r_dat  <= wbs.wbs_dat_i;
                        r_sel  <= wbs.wbs_sel_i;
                        r_we   <= wbs.wbs_we_i;
                        if (w_is_imem && r_cpu_rst) begin
                            r_state      <= ST_XFER;
                            r_lane       <= 2'd0;
                            r_imem_addr  <= {w_off[7:2], 2'b00};
                            r_imem_we    <= wbs.wbs_we_i & wbs.wbs_sel_i[0];
                            r_imem_wdata <= wbs.wbs_dat_i[7:0];
                        end else begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_dat_o <= wbs.wbs_we_i ? 32'd0 : w_rd_val;
                            // The core owns the memory port, so window hits only flag an error.
                            if (w_is_imem) begin
                                r_err <= 1'b1;
                            end else if (w_is_ctrl && wbs.wbs_we_i && wbs.wbs_sel_i[0]) begin
                                r_cpu_rst <= wbs.wbs_dat_i[0];
                                if (wbs.wbs_dat_i[1]) begin
                                    r_err <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_XFER: begin
                    // Read data trails the address by one cycle, hence lane-1.
                    if (!r_we && (r_lane != 2'd0)) begin
                        r_rbuf[{r_lane - 2'd1, 3'b000} +: 8] <= imem_rdata_i;
                    end
                    if (r_lane == 2'd3) begin
                        r_imem_we <= 1'b0;
                        if (r_we) begin
                            r_state <= ST_ACK;
                            r_ack   <= 1'b1;
                            r_dat_o <= 32'd0;
                        end else begin
                            r_state <= ST_CAPT;
                        end
                    end else begin
                        r_lane       <= w_next_lane;
                        r_imem_addr  <= {r_word, w_next_lane};
                        r_imem_we    <= r_we & r_sel[w_next_lane];
                        r_imem_wdata <= get_lane(r_dat, w_next_lane);
                    end
                end
                ST_CAPT: begin
                    r_rbuf[31:24] <= imem_rdata_i;
                    r_state       <= ST_ACK;
                    r_ack         <= 1'b1;
                    r_dat_o       <= {imem_rdata_i, r_rbuf[23:0]};
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b0;
                    r_dat_o <= 32'd0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_dat_o   <= 32'd0;
                    r_imem_we <= 1'b0;
                end
            endcase
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat_o;
    assign cpu_rst_o     = r_cpu_rst;
    assign imem_own_o    = r_cpu_rst;
    assign imem_addr_o   = r_imem_addr;
    assign imem_we_o     = r_imem_we;
    assign imem_wdata_o  = r_imem_wdata;

endmodule

// File: tb/tb_wb_imem_loader.sv
// Scoreboarded bench for wb_imem_loader: a register/memory reference model predicts
// each ack (cycle, data, core-reset state) and each memory write strobe.
module tb_wb_imem_loader;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          cyc;
        logic        cpu_rst;
    } ack_exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rst;
    logic [7:0]  imem_addr;
    logic        imem_we;
    logic [7:0]  imem_wdata;
    logic [7:0]  imem_rdata;
    logic        imem_own;

    logic        init_en;
    logic [7:0]  init_addr;
    logic [7:0]  init_data;
    logic [7:0]  mem [256];

    int          cyc_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          ack_seen = 0;

    logic [7:0]  ref_mem [256];
    logic        ref_cpu_rst;
    logic        ref_err;
    logic [15:0] ref_wcnt;
    ack_exp_t    ack_q [$];
    wr_exp_t     wr_q [$];

    wb_imem_loader_if bus ();

    wb_imem_loader #(.BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs          (bus),
        .cpu_rst_o    (cpu_rst),
        .imem_addr_o  (imem_addr),
        .imem_we_o    (imem_we),
        .imem_wdata_o (imem_wdata),
        .imem_rdata_i (imem_rdata),
        .imem_own_o   (imem_own)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Instruction memory: synchronous read, one cycle latency; preloaded via init port.
    always @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end else if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
        end
        imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // One bus transaction: predict the outcome from the register map, then drive it.
    task automatic do_txn(input logic we, input logic [15:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, input logic drop);
        ack_exp_t    e;
        wr_exp_t     w;
        int          lat;
        logic [31:0] rv;
        logic [7:0]  a;
        logic        got;
        @(negedge clk);
        rv  = 32'd0;
        lat = 1;
        if (off[15:8] == 8'h10) begin
            if (ref_cpu_rst) begin
                lat = we ? 5 : 6;
                for (int i = 0; i < 4; i++) begin
                    a = {off[7:2], 2'b00} + 8'(i);
                    if (we) begin
                        if (sel[i]) begin
                            ref_mem[a] = dat[8*i +: 8];
                            w.addr = a;
                            w.data = dat[8*i +: 8];
                            w.cyc  = cyc_cnt + 1 + i;
                            wr_q.push_back(w);
                            ref_wcnt = ref_wcnt + 16'd1;
                        end
                    end else begin
                        rv[8*i +: 8] = ref_mem[a];
                    end
                end
            end else begin
                ref_err = 1'b1;
            end
        end else if (off == 16'h0000) begin
            rv = {30'd0, ref_err, ref_cpu_rst};
            if (we && sel[0]) begin
                ref_cpu_rst = dat[0];
                if (dat[1]) ref_err = 1'b0;
            end
        end else if (off == 16'h0004) begin
            rv = {16'd0, ref_wcnt};
        end
        e.rd      = !we;
        e.data    = rv;
        e.cyc     = cyc_cnt + lat;
        e.cpu_rst = ref_cpu_rst;
        ack_q.push_back(e);

        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = sel;
        bus.wbs_adr_i = {16'h3000, off};
        bus.wbs_dat_i = dat;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (drop && k == 0) begin
                bus.wbs_stb_i = 1'b0;
                bus.wbs_cyc_i = 1'b0;
            end
            if (bus.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles (off %h)", off);
        end
    endtask

    initial begin
        int         ack_before;
        int         kind;
        logic [15:0] off;
        logic [31:0] d;
        wr_exp_t    w;

        rst           = 1'b1;
        init_en       = 1'b0;
        init_addr     = 8'd0;
        init_data     = 8'd0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'd0;
        bus.wbs_adr_i = 32'd0;
        bus.wbs_dat_i = 32'd0;
        ref_cpu_rst   = 1'b1;
        ref_err       = 1'b0;
        ref_wcnt      = 16'd0;

        fork
            forever begin
                ack_exp_t e;
                wr_exp_t  x;
                @(negedge clk);
                if (bus.wbs_ack_o === 1'b1) begin
                    ack_seen++;
                    if (ack_q.size() == 0) begin
                        check("ack_without_request", {31'd0, bus.wbs_ack_o}, 32'd0);
                    end else begin
                        e = ack_q.pop_front();
                        check("ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
                        if (e.rd) check("read_data", bus.wbs_dat_o, e.data);
                        check("cpu_rst_o", {31'd0, cpu_rst}, {31'd0, e.cpu_rst});
                        check("imem_own_o", {31'd0, imem_own}, {31'd0, e.cpu_rst});
                    end
                end
                if (imem_we === 1'b1 && !init_en) begin
                    if (wr_q.size() == 0) begin
                        check("unexpected_imem_we", {31'd0, imem_we}, 32'd0);
                    end else begin
                        x = wr_q.pop_front();
                        check("imem_addr", {24'd0, imem_addr}, {24'd0, x.addr});
                        check("imem_wdata", {24'd0, imem_wdata}, {24'd0, x.data});
                        check("imem_we_cycle", 32'(cyc_cnt), 32'(x.cyc));
                    end
                end
            end
        join_none

        // Preload memory with random contents while the loader is in reset.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            init_en    = 1'b1;
            init_addr  = 8'(i);
            init_data  = 8'($urandom_range(0, 255));
            ref_mem[i] = init_data;
        end
        @(negedge clk);
        init_en = 1'b0;
        check("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_own", {31'd0, imem_own}, 32'd1);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", {24'd0, imem_wdata}, 32'd0);
        rst = 1'b0;

        do_txn(1'b0, 16'h0000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b0, 16'h0004, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h1004, 32'h4433_2211, 4'hF, 1'b0);
        do_txn(1'b0, 16'h0004, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h1004, 32'hAABB_CCDD, 4'h5, 1'b0);
        do_txn(1'b0, 16'h1004, 32'd0, 4'hF, 1'b0);
        do_txn(1'b0, 16'h0004, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h0000, 32'h0000_0000, 4'h1, 1'b0);
        do_txn(1'b1, 16'h1000, 32'h1234_5678, 4'hF, 1'b0);
        do_txn(1'b0, 16'h1000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b0, 16'h0000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h0000, 32'h0000_0003, 4'hE, 1'b0);
        do_txn(1'b0, 16'h0000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h0000, 32'h0000_0003, 4'h1, 1'b0);
        do_txn(1'b0, 16'h0000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b0, 16'h2000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h0008, 32'hFFFF_FFFF, 4'hF, 1'b0);
        do_txn(1'b1, 16'h10FC, 32'hDEAD_BEEF, 4'hB, 1'b1);
        do_txn(1'b0, 16'h10FC, 32'd0, 4'h0, 1'b1);

        // Leave err set, then reset during lane 2 of a write.
        do_txn(1'b1, 16'h0000, 32'h0000_0000, 4'h1, 1'b0);
        do_txn(1'b0, 16'h1020, 32'd0, 4'hF, 1'b0);
        do_txn(1'b1, 16'h0000, 32'h0000_0001, 4'h1, 1'b0);
        @(negedge clk);
        d = 32'h99AA_BBCC;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = 32'h3000_1010;
        bus.wbs_dat_i = d;
        for (int i = 0; i < 3; i++) begin
            ref_mem[8'h10 + 8'(i)] = d[8*i +: 8];
            w.addr = 8'h10 + 8'(i);
            w.data = d[8*i +: 8];
            w.cyc  = cyc_cnt + 1 + i;
            wr_q.push_back(w);
        end
        ack_before = ack_seen;
        repeat (3) @(negedge clk);
        rst           = 1'b1;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        ref_cpu_rst = 1'b1;
        ref_err     = 1'b0;
        ref_wcnt    = 16'd0;
        repeat (8) @(negedge clk);
        check("abort_no_ack", 32'(ack_seen), 32'(ack_before));
        do_txn(1'b0, 16'h0000, 32'd0, 4'hF, 1'b0);
        do_txn(1'b0, 16'h0004, 32'd0, 4'hF, 1'b0);
        do_txn(1'b0, 16'h1010, 32'd0, 4'hF, 1'b0);

        // Randomised mix of all access kinds.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 11);
            d    = $urandom;
            off  = 16'h1000 | {8'd0, 8'($urandom_range(0, 255)) & 8'hFC};
            case (kind)
                0, 1, 2, 3: do_txn(1'b1, off, d, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
                4, 5, 6:    do_txn(1'b0, off, d, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
                7:          do_txn(1'b0, 16'h0000, d, 4'hF, 1'b0);
                8:          do_txn(1'b0, 16'h0004, d, 4'hF, 1'b0);
                9:          do_txn(1'b1, 16'h0000, {d[31:1], ($urandom_range(0, 3) != 0)},
                                   4'($urandom_range(0, 15)), 1'b0);
                default:    do_txn(d[0], 16'h2000 | {4'd0, d[11:2], 2'b00}, d, 4'hF, 1'b0);
            endcase
        end

        repeat (10) @(negedge clk);
        check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
        check("write_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_imem_loader.md
# wb_imem_loader

Wishbone slave that sits directly behind the user-area Wishbone port and in front of the jacaranda-8 core inside `computer`. The management SoC uses it to hold the core in reset, load the 256 × 8-bit instruction memory through a 32-bit window, read the memory back, and release the core. It serializes each 32-bit bus word into four 8-bit memory accesses and owns the instruction-memory port only while the core is held in reset.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h3000_0000; block responds when `wbs_adr_i[31:16] == BASE_ADDR[31:16]`.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write-enable.
- `wbs_sel_i`  in  4  byte-lane selects.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; valid only while ack is high, 0 otherwise.
- `cpu_rst_o`  out  1  core reset; high holds the core.
- `imem_addr_o`  out  8  instruction-memory byte address.
- `imem_we_o`  out  1  instruction-memory write strobe.
- `imem_wdata_o`  out  8  instruction-memory write data.
- `imem_rdata_i`  in  8  synchronous-read data, 1-cycle latency.
- `imem_own_o`  out  1  equals `cpu_rst_o`; drives the memory-port mux in `computer` (1 = loader owns the port).

## Operation

- Register map, offsets from `BASE_ADDR[15:0]`:
  - 0x0000 CTRL
    - bit0 `cpu_rst`: RW, reset value 1.
    - bit1 `err`: sticky; write 1 to clear.
    - All other bits read 0.
    - Writes take effect only when `sel[0]` is set.
  - 0x0004 WCNT: RO, 16-bit count of IMEM bytes actually written; wraps 0xFFFF→0; bits 31:16 read 0.
  - 0x1000–0x10FF IMEM window.
    - Word at offset `o` maps to bytes `{o[7:2],2'b00} + lane`.
    - Bytes are little-endian: lane `i` = `dat[8i+7:8i]`.
  - Any other offset: acked; reads return 0; writes are ignored.
- FSM states: IDLE, XFER, CAPT, ACK.
  - IDLE, on `stb & cyc`:
    - Latch address, data, sel and we.
    - IMEM window with `cpu_rst_o = 1` → XFER, lane counter = 0.
    - Any other case → ACK.
  - XFER: one lane per cycle, lanes 0..3, always all four lanes regardless of `sel`.
    - `imem_addr_o` = base + lane.
    - Write: `imem_we_o = sel[lane]`, `imem_wdata_o` = that lane's byte; WCNT increments once per asserted `imem_we_o`.
    - Read: `imem_we_o = 0`. During lanes 1..3, capture `imem_rdata_i` into read-buffer lane (lane−1).
    - After lane 3: read → CAPT, write → ACK.
  - CAPT: capture read-buffer lane 3, then → ACK.
  - ACK: `wbs_ack_o = 1` for exactly this cycle, `wbs_dat_o` driven; → IDLE.
- IMEM window access while `cpu_rst_o = 0`:
  - Acked with no memory strobes.
  - Reads return 0.
  - `err` is set to 1.
- Read buffer: bytes whose `sel` bit is 0 still return memory contents.
- A CTRL write that clears `cpu_rst` takes effect in the ACK cycle; the port hands to the core from the next cycle.

## Timing

- Cycle 0 is the first cycle IDLE samples `stb & cyc`.
- Latency to ack:
  - Register or unmapped access: ack in cycle 1.
  - IMEM write: XFER in cycles 1–4, ack in cycle 5.
  - IMEM read: XFER in cycles 1–4, CAPT in cycle 5, ack in cycle 6.
- No new transaction is accepted during the ACK cycle; back-to-back transactions cost one IDLE cycle.
- The master must hold `stb`/`cyc` until ack. If `stb` drops mid-transaction, the block still completes and acks.
- Reset values: `wbs_ack_o` 0, `wbs_dat_o` 0, `cpu_rst_o` 1, `imem_own_o` 1, `imem_we_o` 0, `imem_addr_o` 0, `imem_wdata_o` 0, `err` 0, WCNT 0, FSM IDLE.
- `wb_rst_i` asserted mid-transaction: abort to IDLE the next cycle; no ack; no further `imem_we_o`. Bytes already written stay written.

## Structure

- Shared package `jacaranda_wb_pkg`:
  - Offset constants `CTRL_OFF`, `WCNT_OFF`, `IMEM_BASE_OFF`, `IMEM_SIZE`.
  - State enum `loader_state_t`.
  - Reused later by a data-memory loader.
- Single module, no sub-module; address decode is a few comparators kept inline.

## Test plan

- After reset: CTRL read → 0x0000_0001, ack in cycle 1; WCNT read → 0; `cpu_rst_o = 1`.
- Write 0x4433_2211, `sel` = 0xF, to 0x3000_1004: `imem_we_o` pulses at addresses 4,5,6,7 with data 0x11,0x22,0x33,0x44; ack in cycle 5; WCNT → 4.
- Same write with `sel` = 0x5: only addresses 4 and 6 are written; WCNT +2. Read back 0x3000_1004 → ack in cycle 6 with `dat` = 0x4433_2211 (prior contents in lanes 1 and 3).
- Write CTRL = 0: `cpu_rst_o` falls. Then a write to 0x3000_1000 produces no `imem_we_o`, CTRL reads 0x2. Write CTRL = 0x3: `err` cleared, `cpu_rst_o = 1`.
- Read 0x3000_2000 → 0 with ack in cycle 1. Assert `wb_rst_i` at XFER lane 2 of a write: no ack, lane 3 not written, CTRL reads 0x1.
